scan_fetch_engine: RTL and testbench

SCAN_FETCH_ENGINE -- requirements
Module: scan_fetch_engine

---
 rtl/scan_fetch_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/scan_fetch_engine.sv | 187 ++++++++++++++++++
 tb/tb_scan_fetch_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_fetch_pkg.sv
// Shared constants for the scan fetch engine: FSM state codes, the test-bar
// colour table and the frame-size helper.
package scan_fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam int BAR_COUNT = 8;

    // Must divide evenly and fit in ADDR_W; the instantiating design owns that choice.
    function automatic int words_per_frame(input int h_active, input int v_active,
                                           input int pix_w, input int word_w);
        return (h_active * v_active * pix_w) / word_w;
    endfunction

    function automatic logic [11:0] bar_colour(input logic [2:0] idx);
        logic [11:0] c;
        c = 12'h000;
        case (idx)
            3'd0:    c = 12'hF00;
            3'd1:    c = 12'h0F0;
            3'd2:    c = 12'h00F;
            3'd3:    c = 12'hFFF;
            3'd4:    c = 12'h000;
            3'd5:    c = 12'hFF0;
            3'd6:    c = 12'h0FF;
            3'd7:    c = 12'hF0F;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO: rdata shows the head entry
// whenever empty is low. flush empties it in one cycle.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (do_pop && !do_push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && rst_) mem_q[wr_q] <= wdata;
    end

endmodule

// File: rtl/scan_fetch_engine.sv
// Frame-buffer scan-out: fetches packed words from memory into a FIFO, unpacks
// them LSB-first into pixels, or substitutes an internal colour-bar pattern.
module scan_fetch_engine
    import scan_fetch_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int PIX_W      = 12,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BASE_ADDR  = 0
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        enable,
    input  logic                        test_mode,
    input  logic                        frame_start,
    output logic [ADDR_W-1:0]           df_mem_ptr,
    output logic                        df_rtr_mem,
    input  logic                        mem_rts_df,
    input  logic [WORD_W-1:0]           mem_in_data,
    input  logic                        cb_rtr_df,
    output logic                        df_rts_cb,
    output logic [PIX_W-1:0]            pix_data,
    output logic                        underflow,
    output logic [1:0]                  dbg_state,
    output logic [$clog2(FIFO_DEPTH):0] dbg_fifo_count
);

    localparam int WPF   = words_per_frame(H_ACTIVE, V_ACTIVE, PIX_W, WORD_W);
    localparam int BUF_W = WORD_W + PIX_W - 1;
    localparam int BC_W  = $clog2(BUF_W + 1);
    localparam int H_W   = $clog2(H_ACTIVE);
    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + WPF - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              tm_q, tm_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [H_W-1:0]    h_q, h_d;
    logic              underflow_q, underflow_d;

    logic              flush;
    logic              fetching;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FC_W-1:0]   fifo_count;
    logic [WORD_W-1:0] fifo_rdata;
    logic              take;
    logic              take_mem;
    logic              take_bar;
    logic [BC_W-1:0]   bcnt_left;
    logic [BUF_W-1:0]  buf_left;
    logic [2:0]        bar_idx;
    logic [PIX_W-1:0]  bar_pix;

    // Both interfaces are valid/ready pairs: a word moves when df_rtr_mem and
    // mem_rts_df are high in the same cycle, a pixel when df_rts_cb and
    // cb_rtr_df are; neither side may make its flag depend on the other's.
    assign flush      = frame_start || !enable;
    assign fetching   = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !tm_q;
    assign df_rtr_mem = fetching && !fifo_full;
    assign fifo_push  = df_rtr_mem && mem_rts_df && !flush;
    assign df_rts_cb  = (state_q == ST_RUN) && (tm_q || (bcnt_q >= BC_W'(PIX_W)));
    assign take       = df_rts_cb && cb_rtr_df;
    assign take_mem   = take && !tm_q;
    assign take_bar   = take && tm_q;

    // The refill decision looks at the bit count left after this cycle's pixel,
    // so a word can be appended while a pixel leaves and output never bubbles.
    assign bcnt_left = take_mem ? (bcnt_q - BC_W'(PIX_W)) : bcnt_q;
    assign buf_left  = take_mem ? (buf_q >> PIX_W) : buf_q;
    assign fifo_pop  = fetching && !fifo_empty && (bcnt_left < BC_W'(PIX_W)) && !flush;

    assign bar_idx  = 3'((int'(h_q) * BAR_COUNT) / H_ACTIVE);
    assign bar_pix  = PIX_W'(bar_colour(bar_idx));
    assign pix_data = tm_q ? bar_pix : buf_q[PIX_W-1:0];

    assign df_mem_ptr     = ptr_q;
    assign underflow      = underflow_q;
    assign dbg_state      = state_q;
    assign dbg_fifo_count = fifo_count;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .flush (flush),
        .push  (fifo_push),
        .wdata (mem_in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // test_mode is only latched at frame boundaries so a frame never mixes sources.
    always_comb begin
        state_d = state_q;
        tm_d    = tm_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (frame_start) begin
            state_d = ST_FILL;
            tm_d    = test_mode;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    tm_d    = test_mode;
                end
                ST_FILL: begin
                    if (tm_q || (fifo_count >= FC_W'(FIFO_DEPTH / 2))) state_d = ST_RUN;
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (flush) begin
            ptr_d = FIRST_ADDR;
        end else if (fifo_push) begin
            ptr_d = (ptr_q == LAST_ADDR) ? FIRST_ADDR : (ptr_q + ADDR_W'(1));
        end
    end

    always_comb begin
        buf_d  = buf_left;
        bcnt_d = bcnt_left;
        if (flush) begin
            buf_d  = '0;
            bcnt_d = '0;
        end else if (fifo_pop) begin
            buf_d  = buf_left | (BUF_W'(fifo_rdata) << bcnt_left);
            bcnt_d = bcnt_left + BC_W'(WORD_W);
        end
    end

    always_comb begin
        h_d         = h_q;
        underflow_d = underflow_q;
        if (flush) begin
            h_d = '0;
        end else if (take_bar) begin
            h_d = (h_q == H_W'(H_ACTIVE - 1)) ? '0 : (h_q + H_W'(1));
        end
        if (frame_start) begin
            underflow_d = 1'b0;
        end else if ((state_q == ST_RUN) && cb_rtr_df && !df_rts_cb) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            ptr_q       <= FIRST_ADDR;
            tm_q        <= 1'b0;
            buf_q       <= '0;
            bcnt_q      <= '0;
            h_q         <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tm_q        <= tm_d;
            buf_q       <= buf_d;
            bcnt_q      <= bcnt_d;
            h_q         <= h_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_scan_fetch_engine.sv
// Directed bench for scan_fetch_engine: a small frame (640x4) so pointer wrap
// is reachable; expected pixels are queued up front and checked as they emerge.
module tb_scan_fetch_engine;

    localparam int WORD_W     = 32;
    localparam int PIX_W      = 12;
    localparam int ADDR_W     = 17;
    localparam int FIFO_DEPTH = 16;
    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 4;
    localparam int BASE_ADDR  = 0;
    localparam int WPF        = 960;   // 640*4*12/32 words per frame
    localparam int FRAME_PIX  = 2560;  // 640*4 pixels per frame

    logic                clk = 1'b0;
    logic                rst_ = 1'b0;
    logic                enable = 1'b0;
    logic                test_mode = 1'b0;
    logic                frame_start = 1'b0;
    logic                mem_rts_df = 1'b0;
    logic                cb_rtr_df = 1'b0;
    logic [ADDR_W-1:0]   df_mem_ptr;
    logic                df_rtr_mem;
    logic [WORD_W-1:0]   mem_in_data;
    logic                df_rts_cb;
    logic [PIX_W-1:0]    pix_data;
    logic                underflow;
    logic [1:0]          dbg_state;
    logic [4:0]          dbg_fifo_count;

    logic [PIX_W-1:0]    exp_q[$];
    logic [PIX_W-1:0]    mon_want;
    int                  checks = 0;
    int                  errors = 0;
    int                  rtr_hits = 0;
    int                  granted;
    int                  wrap_seen;
    int                  hit;

    logic                mem_pat = 1'b0;
    logic [WORD_W-1:0]   pat_tbl [0:2];
    logic [PIX_W-1:0]    pat_pix [0:7];
    logic [PIX_W-1:0]    bar_tbl [0:7];

    scan_fetch_engine #(
        .WORD_W     (WORD_W),
        .PIX_W      (PIX_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .BASE_ADDR  (BASE_ADDR)
    ) dut (
        .clk            (clk),
        .rst_           (rst_),
        .enable         (enable),
        .test_mode      (test_mode),
        .frame_start    (frame_start),
        .df_mem_ptr     (df_mem_ptr),
        .df_rtr_mem     (df_rtr_mem),
        .mem_rts_df     (mem_rts_df),
        .mem_in_data    (mem_in_data),
        .cb_rtr_df      (cb_rtr_df),
        .df_rts_cb      (df_rts_cb),
        .pix_data       (pix_data),
        .underflow      (underflow),
        .dbg_state      (dbg_state),
        .dbg_fifo_count (dbg_fifo_count)
    );

    // Clock
    always #5 clk = ~clk;

    // Memory model: either memory[i] = i or a repeating three-word pattern.
    always_comb begin
        if (mem_pat) mem_in_data = pat_tbl[(int'(df_mem_ptr) - BASE_ADDR) % 3];
        else         mem_in_data = WORD_W'(df_mem_ptr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Pixel n of a frame read from memory[i] = i, LSB-first across words.
    function automatic logic [PIX_W-1:0] ramp_pix(input int n);
        int bit0;
        int w;
        int o;
        logic [63:0] pair;
        bit0 = n * PIX_W;
        w    = bit0 / WORD_W;
        o    = bit0 % WORD_W;
        pair = {32'(BASE_ADDR + ((w + 1) % WPF)), 32'(BASE_ADDR + (w % WPF))};
        return PIX_W'(pair >> o);
    endfunction

    // Scoreboard monitor: every accepted pixel is popped and compared.
    always @(negedge clk) begin
        if (rst_ && df_rts_cb && cb_rtr_df) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pix_extra got=%h want=none", pix_data);
            end else begin
                mon_want = exp_q.pop_front();
                check("pix", 32'(pix_data), 32'(mon_want));
            end
        end
    end

    always @(negedge clk) begin
        if (df_rtr_mem) rtr_hits++;
    end

    task automatic pulse_frame_start();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input string name);
        cb_rtr_df = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        cb_rtr_df = 1'b0;
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic push_ramp(input int count);
        for (int n = 0; n < count; n++) exp_q.push_back(ramp_pix(n));
    endtask

    task automatic check_reset_state();
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_ptr", 32'(df_mem_ptr), 32'(BASE_ADDR));
        check("rst_rtr", 32'(df_rtr_mem), 32'd0);
        check("rst_rts", 32'(df_rts_cb), 32'd0);
        check("rst_pix", 32'(pix_data), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_fifo_count", 32'(dbg_fifo_count), 32'd0);
    endtask

    initial begin
        pat_tbl[0] = 32'h76543210;
        pat_tbl[1] = 32'hFEDCBA98;
        pat_tbl[2] = 32'h3210FEDC;
        pat_pix[0] = 12'h210; pat_pix[1] = 12'h543; pat_pix[2] = 12'h876; pat_pix[3] = 12'hBA9;
        pat_pix[4] = 12'hEDC; pat_pix[5] = 12'hDCF; pat_pix[6] = 12'h0FE; pat_pix[7] = 12'h321;
        bar_tbl[0] = 12'hF00; bar_tbl[1] = 12'h0F0; bar_tbl[2] = 12'h00F; bar_tbl[3] = 12'hFFF;
        bar_tbl[4] = 12'h000; bar_tbl[5] = 12'hFF0; bar_tbl[6] = 12'h0FF; bar_tbl[7] = 12'hF0F;

        // Reset
        rst_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();

        // Ramp memory from reset: words 0,1,2,... unpack 8 pixels per 3 words.
        rst_ = 1'b1;
        enable = 1'b1;
        mem_rts_df = 1'b1;
        push_ramp(24);
        drain(200, "ramp_start");
        check("ramp_underflow", 32'(underflow), 32'd0);

        // Nibble pattern: straddling pixels in order, none dropped.
        mem_pat = 1'b1;
        pulse_frame_start();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++) exp_q.push_back(pat_pix[k]);
        drain(200, "pattern");

        // Starvation: grant exactly 12 words, then drain and keep the consumer ready.
        pulse_frame_start();
        granted = 0;
        for (int i = 0; i < 200 && granted < 12; i++) begin
            @(negedge clk);
            if (df_rtr_mem && mem_rts_df) granted++;
        end
        @(posedge clk); #1;
        mem_rts_df = 1'b0;
        check("grant_count", 32'(granted), 32'd12);
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) exp_q.push_back(pat_pix[k]);
        drain(100, "starve");
        cb_rtr_df = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("starve_rts", 32'(df_rts_cb), 32'd0);
        check("starve_underflow", 32'(underflow), 32'd1);
        cb_rtr_df = 1'b0;
        mem_rts_df = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("underflow_sticky", 32'(underflow), 32'd1);

        // Full frame of ramp data with pointer wrap back to the base address.
        mem_pat = 1'b0;
        pulse_frame_start();
        check("fs_clears_underflow", 32'(underflow), 32'd0);
        push_ramp(FRAME_PIX + 24);
        wrap_seen = 0;
        fork
            drain(4000, "ramp_frame");
            begin
                for (int i = 0; i < 4000 && wrap_seen == 0; i++) begin
                    @(negedge clk);
                    if (df_mem_ptr == ADDR_W'(BASE_ADDR + WPF - 1) && df_rtr_mem && mem_rts_df)
                        wrap_seen = 1;
                end
                check("wrap_seen", 32'(wrap_seen), 32'd1);
                if (wrap_seen == 1) begin
                    @(posedge clk); #1;
                    check("ptr_wrap", 32'(df_mem_ptr), 32'(BASE_ADDR));
                end
            end
        join
        check("frame_underflow", 32'(underflow), 32'd0);

        // Colour bars: 80 pixels per bar, no memory requests.
        test_mode = 1'b1;
        pulse_frame_start();
        rtr_hits = 0;
        for (int h = 0; h < H_ACTIVE; h++) exp_q.push_back(bar_tbl[h / 80]);
        drain(800, "bars");
        check("bars_rtr", 32'(rtr_hits), 32'd0);
        check("bars_underflow", 32'(underflow), 32'd0);

        // frame_start coincident with a transfer at 0x100: word discarded, restart.
        test_mode = 1'b0;
        pulse_frame_start();
        push_ramp(1000);
        cb_rtr_df = 1'b1;
        hit = 0;
        for (int i = 0; i < 2000 && hit == 0; i++) begin
            @(posedge clk); #1;
            if (df_mem_ptr == ADDR_W'(BASE_ADDR + 'h100) && df_rtr_mem && mem_rts_df) hit = 1;
        end
        check("ptr_0x100_seen", 32'(hit), 32'd1);
        frame_start = 1'b1;
        cb_rtr_df = 1'b0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        exp_q.delete();
        check("coinc_ptr", 32'(df_mem_ptr), 32'(BASE_ADDR));
        check("coinc_fifo_count", 32'(dbg_fifo_count), 32'd0);
        check("coinc_state", 32'(dbg_state), 32'd1);
        check("coinc_underflow", 32'(underflow), 32'd0);

        // Disable drops to IDLE; reset during fetch leaves no stale bits.
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("disable_state", 32'(dbg_state), 32'd0);
        check("disable_rtr", 32'(df_rtr_mem), 32'd0);
        enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_ = 1'b0;
        @(posedge clk); #1;
        check_reset_state();
        rst_ = 1'b1;
        push_ramp(24);
        drain(200, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
